cardinal_nic: RTL and testbench

CARDINAL_NIC -- requirements
Module: cardinal_nic

---
 rtl/cardinal_nic.sv | 117 +++++++++++
 tb/tb_cardinal_nic.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// cardinal_nic: processor-side network interface with one 64-bit output
// channel buffer (toward the router PE input) and one 64-bit input channel
// buffer (from the router PE output), each with a single full bit.
// Optional feature: define NIC_POLARITY_GATE_EN to hold injection until the
// packet's vc bit (bit 63) differs from the current network polarity.
//
// Handshake (both channels): a transfer happens at a rising edge where the
// sender's send line and the receiver's ready line are both 1; send depends
// on ready combinationally on the output side, and ready never depends on
// send on the input side.
module cardinal_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_so,
  output logic [63:0] net_do,
  input  logic        net_ri,
  input  logic        net_si,
  input  logic [63:0] net_di,
  output logic        net_ro,
  input  logic        polarity
);

  localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  logic [63:0] out_buf_q, out_buf_d;
  logic        out_full_q, out_full_d;
  logic [63:0] in_buf_q, in_buf_d;
  logic        in_full_q, in_full_d;

  logic        cpu_rd;
  logic        out_wr;
  logic        in_rd_clr;
  logic        in_capture;

  assign cpu_rd    = nicEn & ~nicWrEn;
  // A write into a full output buffer is silently dropped, including the
  // edge at which the buffered packet leaves (out_full is still 1 then).
  assign out_wr    = nicEn & nicWrEn & (addr == ADDR_OUT_DATA) & ~out_full_q;
  assign in_rd_clr = cpu_rd & (addr == ADDR_IN_DATA);
  // Ready is low while full, so a packet arriving on the same edge as the
  // draining read is not taken; the router keeps offering it.
  assign in_capture = net_si & net_ro;

  assign net_do = out_buf_q;
  assign net_ro = ~in_full_q;

`ifdef NIC_POLARITY_GATE_EN
  assign net_so = out_full_q & net_ri & (out_buf_q[63] != polarity);
`else
  // Polarity is unused when gating is disabled.
  logic unused_polarity;
  assign unused_polarity = polarity;
  assign net_so = out_full_q & net_ri;
`endif

  // Processor read mux; zero whenever no read is in progress.
  always_comb begin
    d_out = 64'd0;
    if (cpu_rd) begin
      case (addr)
        ADDR_IN_DATA:    d_out = in_buf_q;
        ADDR_IN_STATUS:  d_out = {63'd0, in_full_q};
        ADDR_OUT_DATA:   d_out = out_buf_q;
        ADDR_OUT_STATUS: d_out = {63'd0, out_full_q};
        default:         d_out = 64'd0;
      endcase
    end
  end

  // Next-state for both channel buffers and their full bits.
  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;

    // Send and accept are mutually exclusive: send needs full, write needs empty.
    if (net_so) begin
      out_full_d = 1'b0;
    end else if (out_wr) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end

    // Capture needs empty; draining read only matters when full.
    if (in_capture) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (in_rd_clr) begin
      in_full_d = 1'b0;
    end
  end

  // State registers; reset discards any pending packet in either direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_buf_q  <= 64'd0;
      out_full_q <= 1'b0;
      in_buf_q   <= 64'd0;
      in_full_q  <= 1'b0;
    end else begin
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed testbench for cardinal_nic; expectations follow the build's
// NIC_POLARITY_GATE_EN setting.
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ri;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ro;
  logic        polarity;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [63:0] PKT_A  = 64'h9000_0100_1111_1111;
  localparam logic [63:0] PKT_B  = 64'h8000_0000_0000_0005;
  localparam logic [63:0] PKT_C  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] PKT_D  = 64'h4000_0000_2222_2222;
  localparam logic [63:0] PKT_E  = 64'h0000_0000_0000_7777;
  localparam logic [63:0] PKT_F  = 64'h0000_0000_0000_8888;

  cardinal_nic dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .d_in     (d_in),
    .d_out    (d_out),
    .nicEn    (nicEn),
    .nicWrEn  (nicWrEn),
    .net_so   (net_so),
    .net_do   (net_do),
    .net_ri   (net_ri),
    .net_si   (net_si),
    .net_di   (net_di),
    .net_ro   (net_ro),
    .polarity (polarity)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational read with no edge crossed (no side effects).
  task automatic peek(input logic [1:0] a, input logic [63:0] exp, input string tag);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
    check(tag, d_out, exp);
    nicEn = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  // Read of in-data held across an edge, which drains the input buffer.
  task automatic cpu_read_clear(input logic [63:0] exp, input string tag);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    #1;
    check(tag, d_out, exp);
    tick();
    nicEn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 2'b00; d_in = 64'd0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ri = 1'b0; net_si = 1'b0; net_di = 64'd0; polarity = 1'b0;
    #2;
    check("rst_so", {63'd0, net_so}, 64'd0);
    check("rst_ro", {63'd0, net_ro}, 64'd1);
    check("rst_do", net_do, 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state via status reads
    peek(2'b01, 64'd0, "init_in_status");
    peek(2'b11, 64'd0, "init_out_status");
    check("init_ro", {63'd0, net_ro}, 64'd1);
    check("init_so", {63'd0, net_so}, 64'd0);
    check("idle_dout", d_out, 64'd0);

    // Basic injection: zero-cycle send once written
    net_ri = 1'b1; polarity = 1'b0;
    cpu_write(2'b10, PKT_A);
    check("inj_so", {63'd0, net_so}, 64'd1);
    check("inj_do", net_do, PKT_A);
    peek(2'b11, 64'd1, "inj_full");
    tick();
    check("inj_so_after", {63'd0, net_so}, 64'd0);
    peek(2'b11, 64'd0, "inj_empty");

    // Polarity gating on bit 63
    polarity = 1'b1;
    cpu_write(2'b10, PKT_B);
`ifdef NIC_POLARITY_GATE_EN
    check("pol_block_so", {63'd0, net_so}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pol_hold_so", {63'd0, net_so}, 64'd0);
      peek(2'b11, 64'd1, "pol_hold_full");
    end
    polarity = 1'b0;
    #1;
    check("pol_release_so", {63'd0, net_so}, 64'd1);
    tick();
`else
    check("nogate_so", {63'd0, net_so}, 64'd1);
    tick();
`endif
    check("pol_sent_so", {63'd0, net_so}, 64'd0);
    peek(2'b11, 64'd0, "pol_sent_full");

    // Write to full buffer dropped; then same-edge send + write drops write
    net_ri = 1'b0; polarity = 1'b1;
    cpu_write(2'b10, PKT_C);
    check("blocked_so", {63'd0, net_so}, 64'd0);
    cpu_write(2'b10, 64'hAAAA);
    peek(2'b10, PKT_C, "drop_keep_buf");
    peek(2'b11, 64'd1, "drop_full");
    net_ri = 1'b1;
    #1;
    check("ready_so", {63'd0, net_so}, 64'd1);
    cpu_write(2'b10, 64'hBBBB);
    peek(2'b11, 64'd0, "race_empty");
    peek(2'b10, PKT_C, "race_buf");
    check("race_so", {63'd0, net_so}, 64'd0);

    // Input capture, ignored second packet, draining read
    check("rx_ro_pre", {63'd0, net_ro}, 64'd1);
    net_si = 1'b1; net_di = PKT_D;
    tick();
    net_si = 1'b0;
    check("rx_ro_full", {63'd0, net_ro}, 64'd0);
    peek(2'b01, 64'd1, "rx_status");
    net_si = 1'b1; net_di = 64'h5555;
    tick();
    net_si = 1'b0;
    peek(2'b00, PKT_D, "rx_keep_data");
    peek(2'b01, 64'd1, "rx_still_full");
    cpu_read_clear(PKT_D, "rx_read");
    peek(2'b01, 64'd0, "rx_cleared");
    check("rx_ro_empty", {63'd0, net_ro}, 64'd1);
    peek(2'b00, PKT_D, "rx_data_kept");

    // Same-edge drain and arrival: arrival not captured
    net_si = 1'b1; net_di = PKT_E;
    tick();
    net_si = 1'b0;
    check("race_rx_ro", {63'd0, net_ro}, 64'd0);
    net_si = 1'b1; net_di = PKT_F;
    cpu_read_clear(PKT_E, "race_rx_read");
    net_si = 1'b0;
    peek(2'b01, 64'd0, "race_rx_status");
    check("race_rx_ro_after", {63'd0, net_ro}, 64'd1);
    peek(2'b00, PKT_E, "race_rx_data");
    net_si = 1'b1; net_di = PKT_F;
    tick();
    net_si = 1'b0;
    peek(2'b00, PKT_F, "late_rx_data");
    peek(2'b01, 64'd1, "late_rx_status");

    // Asynchronous reset with both buffers full
    net_ri = 1'b0;
    cpu_write(2'b10, PKT_A);
    peek(2'b11, 64'd1, "pre_rst_out_full");
    #2;
    reset = 1'b1;
    #1;
    peek(2'b01, 64'd0, "arst_in_full");
    peek(2'b11, 64'd0, "arst_out_full");
    check("arst_ro", {63'd0, net_ro}, 64'd1);
    check("arst_so", {63'd0, net_so}, 64'd0);
    check("arst_do", net_do, 64'd0);
    tick();
    reset = 1'b0;
    net_ri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      polarity = i[0];
      tick();
      check("post_rst_so", {63'd0, net_so}, 64'd0);
    end
    peek(2'b10, 64'd0, "post_rst_buf");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
